siso_reg: RTL and testbench



---
 rtl/siso_reg.sv | 73 +++++++
 tb/tb_siso_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/siso_reg.sv
// ---------------------------------------------------------------------------
// siso_reg: serial-in / serial-out shift register with a "primed" flag.
//
// Every rising clk edge shifts si into stage[0] and moves each stage one place
// towards stage[DEPTH-1], which drives so directly from its flop. A saturating
// counter tracks how many bits have entered since the last clear. primed goes
// high once DEPTH bits have been shifted in.
//
// Parameters:
//   DEPTH   number of serial stages (1..64)
//
// Ports:
//   clk     clock; all state updates on its rising edge
//   clear   synchronous active-high reset; has priority over shifting
//   si      serial data in
//   so      serial data out (stage[DEPTH-1])
//   primed  high once DEPTH bits have been shifted in since the last clear
//   q       parallel view of all stages, q[0] newest (SISO_REG_TAP_EN only)
//
// Optional feature macro: SISO_REG_TAP_EN adds the parallel tap port q.
// ---------------------------------------------------------------------------
module siso_reg #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             si,
    output logic             so,
    output logic             primed
`ifdef SISO_REG_TAP_EN
    ,
    output logic [DEPTH-1:0] q
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CountMax = CW'(DEPTH);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;
    logic [CW-1:0]    count_q;

    // Written as a loop so DEPTH=1 needs no special-case slicing.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = si;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // No enable: the chain moves on every edge. si is not masked, so an X or Z
    // on the input travels through the stages for simulation to expose.
    always_ff @(posedge clk) begin
        if (clear) begin
            stage_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            if (count_q != CountMax) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign so     = stage_q[DEPTH-1];
    assign primed = (count_q == CountMax);

`ifdef SISO_REG_TAP_EN
    assign q = stage_q;
`endif

endmodule

// File: tb/tb_siso_reg.sv
// ---------------------------------------------------------------------------
// tb_siso_reg: directed scoreboard bench for siso_reg.
//
// A DEPTH=4 instance and a DEPTH=1 instance share clk/clear/si. The stimulus
// process drives one vector per cycle on the falling edge and pushes the
// hand-computed post-edge outputs into a queue; the monitor pops one entry
// shortly after each rising edge and compares.
// Define SISO_REG_TAP_EN to also check the parallel tap q.
// ---------------------------------------------------------------------------
module tb_siso_reg;

    logic       clk;
    logic       clear;
    logic       si;
    logic       so4;
    logic       primed4;
    logic       so1;
    logic       primed1;
`ifdef SISO_REG_TAP_EN
    logic [3:0] q4;
    logic [0:0] q1;
`endif

    int n_cmp;
    int n_fail;

    typedef struct {
        string      name;
        logic       so;
        logic       primed;
        logic [3:0] q;
        logic       so1;
        logic       primed1;
    } exp_t;

    exp_t sb[$];

    siso_reg #(
        .DEPTH(4)
    ) u_dut4 (
        .clk   (clk),
        .clear (clear),
        .si    (si),
        .so    (so4),
        .primed(primed4)
`ifdef SISO_REG_TAP_EN
        ,
        .q     (q4)
`endif
    );

    siso_reg #(
        .DEPTH(1)
    ) u_dut1 (
        .clk   (clk),
        .clear (clear),
        .si    (si),
        .so    (so1),
        .primed(primed1)
`ifdef SISO_REG_TAP_EN
        ,
        .q     (q1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input string what, input logic act,
                          input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %b, expected %b", name, what, act, req);
        end
    endtask

    task automatic check4(input string name, input string what, input logic [3:0] act,
                          input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %b, expected %b", name, what, act, req);
        end
    endtask

    // One vector: inputs for the next rising edge plus the DEPTH=4 outputs
    // expected after it. The DEPTH=1 instance simply echoes si one edge late.
    task automatic step(input string name, input logic c, input logic s,
                        input logic eso, input logic ep, input logic [3:0] eq);
        exp_t e;
        @(negedge clk);
        clear     = c;
        si        = s;
        e.name    = name;
        e.so      = eso;
        e.primed  = ep;
        e.q       = eq;
        e.so1     = c ? 1'b0 : s;
        e.primed1 = !c;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check1(e.name, "so", so4, e.so);
                check1(e.name, "primed", primed4, e.primed);
                check1(e.name, "so(D1)", so1, e.so1);
                check1(e.name, "primed(D1)", primed1, e.primed1);
`ifdef SISO_REG_TAP_EN
                check4(e.name, "q", q4, e.q);
                check1(e.name, "q(D1)", q1[0], e.so1);
`endif
            end
        end
    end

    // Stimulus
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear  = 1'b1;
        si     = 1'b0;

        // Reset, held for two edges with si ignored
        step("clr_a",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("clr_hold",  1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step("post_clr",  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Single one-cycle pulse
        step("p_clr",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("p_1",       1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        step("p_2",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        step("p_3",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        step("p_4",       1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
        step("p_5",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("p_6",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

        // Sequence 1,0,0,1,0 reappears on so
        step("s_clr",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("s_1",       1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        step("s_2",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        step("s_3",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        step("s_4",       1'b0, 1'b1, 1'b1, 1'b1, 4'b1001);
        step("s_5",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
        step("s_6",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
        step("s_7",       1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
        step("s_8",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

        // Shift 1,1,1 then clear mid-stream
        step("m_1",       1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        step("m_2",       1'b0, 1'b1, 1'b0, 1'b1, 4'b0011);
        step("m_3",       1'b0, 1'b1, 1'b0, 1'b1, 4'b0111);
        step("m_clr",     1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step("m_4",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("m_5",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("m_6",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // X on si travels through untouched
        step("x_1",       1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        step("x_2",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
        step("x_in",      1'b0, 1'bx, 1'b0, 1'b1, 4'b010x);
        step("x_3",       1'b0, 1'b0, 1'b1, 1'b1, 4'b10x0);
        step("x_4",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0x00);
        step("x_out",     1'b0, 1'b0, 1'bx, 1'b1, 4'bx000);
        step("x_gone",    1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

        // Tap pattern 1,0,1,1 (q[0] newest)
        step("t_clr",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("t_1",       1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        step("t_2",       1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        step("t_3",       1'b0, 1'b1, 1'b0, 1'b0, 4'b0101);
        step("t_4",       1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);

        // Drain: allow the monitor a bounded number of cycles to empty the queue
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
